// File: rtl/noise_gate_pkg.sv
// Shared types, widths and the saturating gain multiply for the noise gate.
package noise_gate_pkg;

    typedef enum logic [2:0] {CLOSED, ATTACK, OPEN, HOLD, RELEASE} gate_state_t;
    typedef logic [1:0] phase_t;

    localparam int GAIN_W = 17;
    localparam int ENV_W  = 18;
    localparam logic [GAIN_W-1:0] GAIN_UNITY = 17'd32768;

    // Q1.15 gain applied to a signed sample; result clamped to the 16-bit range.
    function automatic logic signed [15:0] scale_sample(input logic signed [15:0] x,
                                                        input logic [GAIN_W-1:0] g);
        logic signed [32:0] prod;
        logic signed [32:0] shifted;
        prod    = 33'(x) * 33'($signed({1'b0, g}));
        shifted = prod >>> 15;
        if (shifted > 33'sd32767)
            return 16'sh7FFF;
        else if (shifted < -33'sd32768)
            return 16'sh8000;
        else
            return shifted[15:0];
    endfunction

endpackage

// File: rtl/noise_gate_if.sv
// Sample-path signals between the highpass stage, the noise gate and its consumer.
interface noise_gate_if;
    logic               enable;
    logic signed [15:0] gate_in;
    logic signed [15:0] gate_out;
    logic               gate_open;
    logic [15:0]        env_level;

    modport master (output enable, gate_in, input gate_out, gate_open, env_level);
    modport slave  (input enable, gate_in, output gate_out, gate_open, env_level);
endinterface

// File: rtl/noise_gate_envelope_follower.sv
// Peak envelope follower: one-pole smoothing of |sample| once per strobe.
module envelope_follower
    import noise_gate_pkg::*;
#(
    parameter int ENV_SHIFT = 6
) (
    input  logic               clk_144,
    input  logic               reset_n,
    input  logic               clear,
    input  logic               strobe,
    input  logic signed [15:0] sample_in,
    output logic [15:0]        env_out
);

    logic [15:0]             abs_x;
    logic signed [ENV_W-1:0] diff;
    logic signed [ENV_W-1:0] env_next;
    logic signed [ENV_W-1:0] env_reg;
    logic [15:0]             env_out_reg;

    always_comb begin
        // -32768 has no positive 16-bit counterpart, so it saturates.
        if (sample_in == 16'sh8000)
            abs_x = 16'h7FFF;
        else if (sample_in < 16'sd0)
            abs_x = 16'(-sample_in);
        else
            abs_x = sample_in;
        diff     = $signed({2'b00, abs_x}) - env_reg;
        env_next = env_reg + (diff >>> ENV_SHIFT);
    end

    always_ff @(posedge clk_144 or negedge reset_n) begin
        if (!reset_n) begin
            env_reg     <= '0;
            env_out_reg <= '0;
        end else if (clear) begin
            env_reg     <= '0;
            env_out_reg <= '0;
        end else if (strobe) begin
            env_reg     <= env_next;
            env_out_reg <= env_next[15:0];
        end
    end

    assign env_out = env_out_reg;

endmodule

// File: rtl/noise_gate.sv
// Noise gate: envelope-driven attack/hold/release gain on a 3-clock sample frame.
module noise_gate
    import noise_gate_pkg::*;
#(
    parameter int OPEN_THRESH  = 1024,
    parameter int CLOSE_THRESH = 512,
    parameter int HOLD_SAMPLES = 2400,
    parameter int ATTACK_STEP  = 1024,
    parameter int RELEASE_STEP = 16,
    parameter int ENV_SHIFT    = 6
) (
    input  logic       clk_144,
    input  logic       reset_n,
    noise_gate_if.slave bus
);

    phase_t             phase_reg;
    gate_state_t        state_reg;
    logic [GAIN_W-1:0]  gain_reg;
    logic [15:0]        hold_cnt_reg;
    logic signed [15:0] x_reg;
    logic signed [15:0] gate_out_reg;
    logic               gate_open_reg;

    logic [15:0]        env_level;
    logic               env_clear;
    logic               env_strobe;
    logic [GAIN_W:0]    attack_sum;
    logic [GAIN_W-1:0]  attack_gain;
    logic [GAIN_W-1:0]  release_gain;
    logic               env_high;
    logic               env_low;

    assign env_clear  = (phase_reg == 2'd3);
    assign env_strobe = (phase_reg == 2'd1);

    envelope_follower #(.ENV_SHIFT(ENV_SHIFT)) u_env (
        .clk_144   (clk_144),
        .reset_n   (reset_n),
        .clear     (env_clear),
        .strobe    (env_strobe),
        .sample_in (x_reg),
        .env_out   (env_level)
    );

    always_comb begin
        attack_sum   = {1'b0, gain_reg} + 18'(ATTACK_STEP);
        attack_gain  = (attack_sum >= {1'b0, GAIN_UNITY}) ? GAIN_UNITY : attack_sum[GAIN_W-1:0];
        release_gain = (gain_reg > 17'(RELEASE_STEP)) ? gain_reg - 17'(RELEASE_STEP) : '0;
        env_high     = (env_level >= 16'(OPEN_THRESH));
        env_low      = (env_level < 16'(CLOSE_THRESH));
    end

    always_ff @(posedge clk_144 or negedge reset_n) begin
        if (!reset_n) begin
            phase_reg     <= 2'd0;
            state_reg     <= CLOSED;
            gain_reg      <= '0;
            hold_cnt_reg  <= '0;
            x_reg         <= '0;
            gate_out_reg  <= '0;
            gate_open_reg <= 1'b0;
        end else begin
            case (phase_reg)
                2'd0: begin
                    x_reg     <= bus.gate_in;
                    phase_reg <= 2'd1;
                end
                2'd1: phase_reg <= 2'd2;
                2'd2: begin
                    phase_reg <= 2'd0;
                    if (!bus.enable) begin
                        // Bypass keeps the gate parked open so re-enabling starts at unity.
                        state_reg     <= OPEN;
                        gain_reg      <= GAIN_UNITY;
                        hold_cnt_reg  <= '0;
                        gate_out_reg  <= x_reg;
                        gate_open_reg <= 1'b1;
                    end else begin
                        case (state_reg)
                            CLOSED: begin
                                gain_reg      <= '0;
                                gate_out_reg  <= scale_sample(x_reg, '0);
                                gate_open_reg <= env_high;
                                if (env_high) state_reg <= ATTACK;
                            end
                            ATTACK: begin
                                gain_reg      <= attack_gain;
                                gate_out_reg  <= scale_sample(x_reg, attack_gain);
                                gate_open_reg <= 1'b1;
                                if (attack_gain == GAIN_UNITY) state_reg <= OPEN;
                            end
                            OPEN: begin
                                gain_reg      <= GAIN_UNITY;
                                gate_out_reg  <= scale_sample(x_reg, GAIN_UNITY);
                                gate_open_reg <= 1'b1;
                                if (env_low) begin
                                    state_reg    <= HOLD;
                                    hold_cnt_reg <= 16'(HOLD_SAMPLES - 1);
                                end
                            end
                            HOLD: begin
                                gain_reg      <= GAIN_UNITY;
                                gate_out_reg  <= scale_sample(x_reg, GAIN_UNITY);
                                gate_open_reg <= 1'b1;
                                if (env_high)
                                    state_reg <= OPEN;
                                else if (hold_cnt_reg == 16'd0)
                                    state_reg <= RELEASE;
                                else
                                    hold_cnt_reg <= hold_cnt_reg - 16'd1;
                            end
                            RELEASE: begin
                                // A retrigger resumes the attack from wherever the ramp stands.
                                if (env_high) begin
                                    state_reg     <= ATTACK;
                                    gate_out_reg  <= scale_sample(x_reg, gain_reg);
                                    gate_open_reg <= 1'b1;
                                end else begin
                                    gain_reg      <= release_gain;
                                    gate_out_reg  <= scale_sample(x_reg, release_gain);
                                    gate_open_reg <= (release_gain != '0);
                                    if (release_gain == '0) state_reg <= CLOSED;
                                end
                            end
                            default: begin
                                state_reg     <= CLOSED;
                                gain_reg      <= '0;
                                gate_out_reg  <= '0;
                                gate_open_reg <= 1'b0;
                            end
                        endcase
                    end
                end
                default: begin
                    phase_reg     <= 2'd0;
                    state_reg     <= CLOSED;
                    gain_reg      <= '0;
                    hold_cnt_reg  <= '0;
                    x_reg         <= '0;
                    gate_out_reg  <= '0;
                    gate_open_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gate_out  = gate_out_reg;
    assign bus.gate_open = gate_open_reg;
    assign bus.env_level = env_level;

endmodule

// File: tb/tb_noise_gate.sv
// Scoreboarded bench for noise_gate: per-frame reference model vs. DUT outputs.
module tb_noise_gate;

    localparam int OPEN_T  = 1024;
    localparam int CLOSE_T = 512;
    localparam int HOLD_N  = 2400;
    localparam int ATK     = 1024;
    localparam int REL     = 16;
    localparam int ENV_DIV = 64;
    localparam int UNITY   = 32768;

    localparam int S_CLOSED  = 0;
    localparam int S_ATTACK  = 1;
    localparam int S_OPEN    = 2;
    localparam int S_HOLD    = 3;
    localparam int S_RELEASE = 4;

    logic clk_144 = 1'b0;
    logic reset_n = 1'b0;

    noise_gate_if ng_if ();

    noise_gate #(
        .OPEN_THRESH  (OPEN_T),
        .CLOSE_THRESH (CLOSE_T),
        .HOLD_SAMPLES (HOLD_N),
        .ATTACK_STEP  (ATK),
        .RELEASE_STEP (REL),
        .ENV_SHIFT    (6)
    ) dut (
        .clk_144 (clk_144),
        .reset_n (reset_n),
        .bus     (ng_if.slave)
    );

    always #5 clk_144 = ~clk_144;

    typedef struct {
        int frame;
        int out;
        bit open;
        int env;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    int   frame_no = 0;

    // Reference model state (one step per audio frame).
    int m_st, m_gain, m_hold, m_env;

    // Frame timing reference: which clock edge of the 3-edge frame just happened.
    int tb_phase;
    bit out_edge;
    always @(posedge clk_144 or negedge reset_n) begin
        if (!reset_n) begin
            tb_phase <= 0;
            out_edge <= 1'b0;
        end else begin
            out_edge <= (tb_phase == 2);
            tb_phase <= (tb_phase == 2) ? 0 : tb_phase + 1;
        end
    end

    task automatic check(input string name, input int frame, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s frame=%0d got=%0d expected=%0d", name, frame, got, exp);
        end
    endtask

    function automatic int scale_ref(input int x, input int g);
        longint p, q;
        p = longint'(x) * longint'(g);
        if (p >= 0) q = p / 32768;
        else        q = -((-p + 32767) / 32768);
        if (q > 32767)  q = 32767;
        if (q < -32768) q = -32768;
        return int'(q);
    endfunction

    task automatic model_reset();
        m_st = S_CLOSED; m_gain = 0; m_hold = 0; m_env = 0;
    endtask

    task automatic model_step(input bit en, input int x, output exp_t e);
        int a, d, out;
        bit hi, lo;
        a = (x == -32768) ? 32767 : ((x < 0) ? -x : x);
        d = a - m_env;
        if (d >= 0) m_env = m_env + d / ENV_DIV;
        else        m_env = m_env - (-d + ENV_DIV - 1) / ENV_DIV;
        hi = (m_env >= OPEN_T);
        lo = (m_env < CLOSE_T);
        if (!en) begin
            m_st = S_OPEN; m_gain = UNITY; m_hold = 0;
            out = x;
        end else begin
            case (m_st)
                S_CLOSED: begin
                    m_gain = 0;
                    if (hi) m_st = S_ATTACK;
                end
                S_ATTACK: begin
                    m_gain = (m_gain + ATK > UNITY) ? UNITY : m_gain + ATK;
                    if (m_gain == UNITY) m_st = S_OPEN;
                end
                S_OPEN: begin
                    m_gain = UNITY;
                    if (lo) begin m_st = S_HOLD; m_hold = HOLD_N - 1; end
                end
                S_HOLD: begin
                    if (hi) m_st = S_OPEN;
                    else if (m_hold == 0) m_st = S_RELEASE;
                    else m_hold--;
                end
                default: begin
                    if (hi) m_st = S_ATTACK;
                    else begin
                        m_gain = (m_gain > REL) ? m_gain - REL : 0;
                        if (m_gain == 0) m_st = S_CLOSED;
                    end
                end
            endcase
            out = scale_ref(x, m_gain);
        end
        e.frame = frame_no;
        e.out   = out;
        e.open  = (m_st != S_CLOSED);
        e.env   = m_env;
    endtask

    // Called at the falling edge just before a capture edge; returns at the next such edge.
    task automatic do_frame(input bit en, input int x);
        exp_t e;
        ng_if.enable  = en;
        ng_if.gate_in = 16'(x);
        model_step(en, x, e);
        exp_q.push_back(e);
        frame_no++;
        repeat (3) @(negedge clk_144);
    endtask

    task automatic run_until_release(input int gain_max);
        int n;
        n = 0;
        while (!(m_st == S_RELEASE && m_gain <= gain_max) && n < 8000) begin
            do_frame(1'b1, 100);
            n++;
        end
    endtask

    // Monitor: one DUT result per frame, presented after the phase-2 edge.
    always @(negedge clk_144) begin
        if (reset_n && out_edge) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scoreboard_underflow got=output_frame expected=none_pending");
            end else begin
                mon_e = exp_q.pop_front();
                check("gate_out",  mon_e.frame, int'(ng_if.gate_out),  mon_e.out);
                check("gate_open", mon_e.frame, int'(ng_if.gate_open), int'(mon_e.open));
                check("env_level", mon_e.frame, int'(ng_if.env_level), mon_e.env);
                $display("frame=%0d in=%0d en=%0d out=%0d open=%0d env=%0d", mon_e.frame,
                         int'(ng_if.gate_in), ng_if.enable, int'(ng_if.gate_out),
                         ng_if.gate_open, ng_if.env_level);
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int amps[5];
        amps[0] = 50; amps[1] = 300; amps[2] = 1500; amps[3] = 8000; amps[4] = 32767;
        ng_if.enable  = 1'b1;
        ng_if.gate_in = 16'sd0;

        #12;
        check("reset_gate_out",  -1, int'(ng_if.gate_out),  0);
        check("reset_gate_open", -1, int'(ng_if.gate_open), 0);
        check("reset_env_level", -1, int'(ng_if.env_level), 0);
        @(negedge clk_144);
        @(negedge clk_144);
        reset_n = 1'b1;
        model_reset();

        repeat (100)  do_frame(1'b1, 0);
        repeat (60)   do_frame(1'b1, 8000);
        repeat (4700) do_frame(1'b1, 100);

        // Retrigger out of a half-finished release.
        repeat (60) do_frame(1'b1, 8000);
        run_until_release(16384 + 9 * REL);
        repeat (40) do_frame(1'b1, 8000);

        // Bypass and full-scale negative input.
        repeat (10)  do_frame(1'b0, -32768);
        repeat (300) do_frame(1'b1, -32768);

        for (int s = 0; s < 30; s++) begin
            int amp, len;
            bit en;
            amp = amps[$urandom_range(0, 4)];
            len = int'($urandom_range(20, 150));
            en  = ($urandom_range(0, 7) != 0);
            for (int i = 0; i < len; i++) begin
                int x;
                x = int'($urandom_range(0, 2 * amp)) - amp;
                if (amp == 32767 && $urandom_range(0, 15) == 0) x = -32768;
                do_frame(en, x);
            end
        end

        // Asynchronous reset in the middle of a release ramp.
        repeat (60) do_frame(1'b1, 8000);
        run_until_release(UNITY - 10 * REL);
        #1;
        check("queue_drained_before_reset", frame_no, exp_q.size(), 0);
        @(posedge clk_144);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_gate_out",  frame_no, int'(ng_if.gate_out),  0);
        check("async_reset_gate_open", frame_no, int'(ng_if.gate_open), 0);
        check("async_reset_env_level", frame_no, int'(ng_if.env_level), 0);
        repeat (2) @(posedge clk_144);
        @(negedge clk_144);
        reset_n = 1'b1;
        model_reset();
        repeat (20) do_frame(1'b1, 0);
        repeat (50) do_frame(1'b1, 8000);
        repeat (30) do_frame(1'b1, -2000);

        #1;
        check("queue_drained_at_end", frame_no, exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
